conv_mac_feeder: RTL and testbench

- Operand sequencer and result collector that sits on the MAC input/output interface of the convolution datapath.
- Holds one input vector x and one weight vector w in local register arrays, loaded through a simple write port.
- On start: issues a clear to the MAC, streams LEN (a,b) pairs with a valid strobe, counts returned MAC valid pulses, then captures the final accumulated value as the dot product y.

---
 rtl/conv_mac_feeder.sv | 181 ++++++++++++++++++
 tb/tb_conv_mac_feeder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_feeder.sv
// conv_mac_feeder: operand sequencer and result collector for the convolution MAC.
//
// Holds one x vector and one w vector in local register arrays, loaded through a
// simple write port. A start pulse clears the MAC and streams LEN (x[i], w[i])
// pairs with a valid strobe. The block then counts the MAC's valid returns and
// captures the final accumulator value as the dot product y.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_en/sel/addr/data operand array write port (sel 0 = x, 1 = w)
//   start               single-cycle start pulse
//   mac_clr/a/b/valid   registered drive to the MAC
//   mac_f/valid_out     MAC accumulator and its valid strobe
//   y, y_valid          captured dot product and one-cycle update pulse
//   busy, err           activity flag; sticky timeout flag
//
// Optional build macro: FEEDER_RELU_EN clamps a negative captured result to zero.
module conv_mac_feeder #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned LEN     = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic                        wr_sel,
  input  logic [$clog2(LEN)-1:0]      wr_addr,
  input  logic signed [WIDTH-1:0]     wr_data,
  input  logic                        start,
  output logic                        mac_clr,
  output logic signed [WIDTH-1:0]     mac_a,
  output logic signed [WIDTH-1:0]     mac_b,
  output logic                        mac_valid,
  input  logic signed [2*WIDTH-1:0]   mac_f,
  input  logic                        mac_valid_out,
  output logic signed [2*WIDTH-1:0]   y,
  output logic                        y_valid,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned AW = $clog2(LEN);
  localparam int unsigned RW = $clog2(LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LastIdx     = AW'(LEN - 1);
  localparam logic [RW-1:0] LenCnt      = RW'(LEN);
  localparam logic [RW-1:0] LenLast     = RW'(LEN - 1);
  localparam logic [WW-1:0] TimeoutLast = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StWait, StDone} state_e;

  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [RW-1:0] ret_q, ret_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          accept_start, capture, timeout;

  logic signed [WIDTH-1:0] x_mem [LEN];
  logic signed [WIDTH-1:0] w_mem [LEN];

  logic signed [WIDTH-1:0]   mac_a_d, mac_b_d;
  logic signed [2*WIDTH-1:0] y_d;
  logic                      mac_clr_d, mac_valid_d, y_valid_d, busy_d, err_d;

  logic idle_like;
  assign idle_like = (state_q == StIdle) || (state_q == StDone);

  // Operand arrays: writable only while the sequencer is not using them.
  always_ff @(posedge clk) begin
    if (wr_en && idle_like && ({1'b0, wr_addr} < LEN[AW:0])) begin
      if (wr_sel) w_mem[wr_addr] <= wr_data;
      else        x_mem[wr_addr] <= wr_data;
    end
  end

  // State and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ret_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
    end
  end

  // Next state
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ret_d        = ret_q;
    wait_d       = wait_q;
    accept_start = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;

    // Returns overlap RUN because the MAC latency is shorter than LEN.
    if ((state_q == StRun || state_q == StWait) && mac_valid_out && (ret_q != LenCnt)) begin
      ret_d   = ret_q + 1'b1;
      capture = (ret_q == LenLast);
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = StClear;
          idx_d        = '0;
          ret_d        = '0;
          wait_d       = '0;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        if (idx_q == LastIdx) state_d = StWait;
        else                  idx_d   = idx_q + 1'b1;
      end
      StWait: begin
        if (ret_q == LenCnt) begin
          state_d = StDone;
        end else if ((wait_q == TimeoutLast) && !capture) begin
          // A capture landing on the last WAIT cycle counts as success.
          timeout = 1'b1;
          state_d = StDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next values, derived from the upcoming state so outputs stay registered.
  always_comb begin
    mac_clr_d   = (state_d == StClear);
    mac_valid_d = (state_d == StRun);
    mac_a_d     = mac_valid_d ? x_mem[idx_d] : '0;
    mac_b_d     = mac_valid_d ? w_mem[idx_d] : '0;
    busy_d      = (state_d == StClear) || (state_d == StRun) || (state_d == StWait);
    y_valid_d   = capture;
    y_d         = y;
    if (capture) begin
`ifdef FEEDER_RELU_EN
      y_d = mac_f[2*WIDTH-1] ? '0 : mac_f;
`else
      y_d = mac_f;
`endif
    end
    err_d = err;
    if (accept_start) err_d = 1'b0;
    if (timeout)      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_clr   <= 1'b0;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mac_clr   <= mac_clr_d;
      mac_valid <= mac_valid_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      y         <= y_d;
      y_valid   <= y_valid_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_mac_feeder.sv
module tb_conv_mac_feeder;

  localparam int W   = 14;
  localparam int LEN = 8;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [2:0] wr_addr = '0;
  logic signed [W-1:0] wr_data = '0;
  logic start = 1'b0;
  logic mac_clr, mac_valid, y_valid, busy, err;
  logic signed [W-1:0] mac_a, mac_b;
  logic signed [2*W-1:0] mac_f, y;
  logic mac_valid_out;

  always #5 clk = ~clk;

  conv_mac_feeder #(.WIDTH(W), .LEN(LEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(mac_valid), .mac_f(mac_f), .mac_valid_out(mac_valid_out), .y(y),
    .y_valid(y_valid), .busy(busy), .err(err)
  );

  // Behavioural MAC: valid_out three edges after valid_in, f already includes the product.
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic signed [2*W-1:0] p1 = '0, p2 = '0, acc = '0;
  logic mac_block = 1'b0;
  always @(posedge clk) begin
    v1 <= mac_valid;
    p1 <= mac_a * mac_b;
    v2 <= v1;
    p2 <= p1;
    v3 <= v2;
    if (mac_clr) acc <= '0;
    else if (v2) acc <= acc + p2;
  end
  assign mac_f = acc;
  assign mac_valid_out = v3 & ~mac_block;

  // Reference model of the operand arrays
  longint mx [LEN];
  longint mw [LEN];

  int n_tests = 0;
  int n_fail = 0;
  int vcount, ycount, clrcount;
  int k = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_y();
    longint s = 0;
    for (int i = 0; i < LEN; i++) s += mx[i] * mw[i];
`ifdef FEEDER_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (!reset) begin
      if (mac_clr) begin
        k = 0;
        clrcount++;
      end
      if (mac_valid) begin
        vcount++;
        if (k < LEN) begin
          chk("mac_a_stream", mac_a, mx[k]);
          chk("mac_b_stream", mac_b, mw[k]);
        end else begin
          chk("extra_mac_valid", k, LEN - 1);
        end
        k++;
      end else begin
        chk("mac_a_idle_zero", mac_a, 0);
        chk("mac_b_idle_zero", mac_b, 0);
      end
      if (y_valid) begin
        ycount++;
        chk("y_vs_model", y, model_y());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input longint data);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = 3'(addr);
    wr_data = W'(data);
    cyc();
    wr_en = 1'b0;
    if (sel) mw[addr] = data;
    else     mx[addr] = data;
  endtask

  task automatic run(input longint exp_y, input bit disturb);
    bit got = 0;
    vcount = 0;
    ycount = 0;
    clrcount = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("clr_after_start", mac_clr, 1);
    chk("busy_in_clear", busy, 1);
    chk("valid_low_in_clear", mac_valid, 0);
    chk("err_cleared_by_start", err, 0);
    cyc();
    chk("valid_first_run", mac_valid, 1);
    if (disturb) begin
      start = 1'b1;
      wr_en = 1'b1;
      wr_sel = 1'b0;
      wr_addr = 3'd0;
      wr_data = 14'sd99;
      cyc();
      start = 1'b0;
      wr_sel = 1'b1;
      wr_addr = 3'd3;
      cyc();
      wr_en = 1'b0;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      cyc();
      if (y_valid) got = 1;
    end
    chk("y_valid_seen", got, 1);
    if (got) begin
      chk("y_value", y, exp_y);
      chk("busy_at_y_valid", busy, 1);
      cyc();
      chk("busy_fall", busy, 0);
      chk("y_valid_one_cycle", y_valid, 0);
      chk("y_hold", y, exp_y);
    end
    chk("mac_valid_count", vcount, LEN);
    chk("y_valid_count", ycount, 1);
    chk("mac_clr_count", clrcount, 1);
  endtask

  initial begin
    int nb;
    cyc();
    cyc();
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    cyc();

    // Scenario 1: x = 1..8, w = 2 -> 72
    for (int i = 0; i < LEN; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < LEN; i++) load(1'b1, i, 2);
    run(72, 1'b0);

    // Scenario 2: x = -3, w = 5 -> -120 (clamped to 0 with ReLU)
    for (int i = 0; i < LEN; i++) load(1'b0, i, -3);
    for (int i = 0; i < LEN; i++) load(1'b1, i, 5);
`ifdef FEEDER_RELU_EN
    run(0, 1'b0);
`else
    run(-120, 1'b0);
`endif

    // Scenario 3: restart and writes during RUN are ignored
    for (int i = 0; i < LEN; i++) load(1'b0, i, i + 1);
    for (int i = 0; i < LEN; i++) load(1'b1, i, 2);
    run(72, 1'b1);
    run(72, 1'b0);

    // Scenario 4: reset in the 4th RUN cycle
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("run4_valid", mac_valid, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_mac_valid", mac_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_y", y, 0);
    ycount = 0;
    repeat (10) cyc();
    chk("midrst_no_y_valid", ycount, 0);
    run(72, 1'b0);

    // Scenario 5: MAC never returns -> timeout
    mac_block = 1'b1;
    vcount = 0;
    ycount = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    nb = 1;
    for (int i = 0; i < 200 && busy; i++) begin
      cyc();
      if (busy) nb++;
    end
    chk("timeout_busy_cycles", nb, 1 + LEN + TO);
    chk("timeout_err", err, 1);
    chk("timeout_no_y_valid", ycount, 0);
    chk("timeout_y_unchanged", y, 72);
    repeat (3) cyc();
    chk("err_sticky", err, 1);
    mac_block = 1'b0;
    run(72, 1'b0);

    // Scenario 6: back-to-back start in DONE right after y_valid
    run(72, 1'b0);
    run(72, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
